date_ctrl: RTL
==============

DATE_CTRL -- requirements
Module: date_ctrl

Interface
REQ-001 Parameter DAY_RST, default 1: day value loaded at reset, legal range 1..31 (January).
REQ-002 Parameter MONTH_RST, default 1: month value loaded at reset, legal range 1..12.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port list SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- tick_day  in  1  single-cycle pulse, day rollover from time-of-day chain.
- btn_mode  in  1  single-cycle debounced pulse, cycle edit mode.
- btn_up  in  1  single-cycle debounced pulse, increment selected field.
- btn_down  in  1  single-cycle debounced pulse, decrement selected field.
- leap  in  1  leap flag of the current year, from the year counter (valid one cycle after any year pulse).
- day  out  5  current day, 1..31.
- month  out  4  current month, 1..12.
- year_inc_auto  out  1  registered pulse, year +1 (calendar rollover).
- year_inc_manual  out  1  registered pulse, year +1 (edit).
- year_dec_manual  out  1  registered pulse, year -1 (edit).
- mode  out  2  0 RUN, 1 EDIT_YEAR, 2 EDIT_MONTH, 3 EDIT_DAY.

Function
REQ-005 All outputs SHALL be registered; at most one of the three year pulses SHALL be high in any cycle, each for exactly one cycle.
REQ-006 FSM states RUN, EDIT_YEAR, EDIT_MONTH, EDIT_DAY; btn_mode SHALL step RUN->EDIT_YEAR->EDIT_MONTH->EDIT_DAY->RUN, one step per pulse.
REQ-007 In a cycle with btn_mode high, btn_up/btn_down SHALL be ignored.
REQ-008 btn_up and btn_down high in the same cycle SHALL cause no action.
REQ-009 btn_up/btn_down SHALL be ignored in RUN.
REQ-010 Days-in-month (dim): 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; for month 2, 29 if leap else 28.
REQ-011 In RUN, on tick_day: if day<dim, day+1; else day=1 and month+1, or, if month=12, month=1 with year_inc_auto asserted the next cycle edge, concurrent with the day/month update.
REQ-012 A tick_day arriving in any EDIT state SHALL set a pending flag (at most one tick stored; further ticks are dropped); the pending tick SHALL be applied per REQ-011 in the first RUN cycle after exit, and the flag cleared.
REQ-013 A tick_day in the same cycle that a pending tick is applied SHALL itself become pending, so no tick is lost when two are queued.
REQ-014 EDIT_YEAR: btn_up -> year_inc_manual pulse; btn_down -> year_dec_manual pulse; day/month unchanged that cycle.
REQ-015 EDIT_MONTH: btn_up wraps 12->1; btn_down wraps 1->12; year unaffected.
REQ-016 EDIT_DAY: btn_up wraps dim->1; btn_down wraps 1->dim, using dim of the current month/leap.
REQ-017 Clamp: in any cycle where no other day update occurs and day>dim, day SHALL be set to dim (Feb 29 becomes Feb 28 two cycles after a year pulse into a non-leap year, one cycle after a month edit).
REQ-018 day SHALL never take value 0 or exceed 31; month SHALL never take 0 or exceed 12.

Reset
REQ-019 While rst is high at a clock edge: mode=RUN, day=DAY_RST, month=MONTH_RST, all year pulses 0, pending flag cleared; reset overrides every input that cycle.
REQ-020 Reset asserted mid-edit SHALL discard any pending tick and return to RUN with no year pulse emitted.

Verification
REQ-021 Day 28, month 2, leap=0, tick_day -> day 1, month 3, no year pulse; repeat with leap=1 -> day 29, month 2.
REQ-022 Day 31, month 12, tick_day in RUN -> day 1, month 1, year_inc_auto high exactly one cycle.
REQ-023 4x btn_mode from RUN -> mode 1,2,3,0; in mode 2 from month 1, btn_down -> month 12; btn_up+btn_down together -> no change.
REQ-024 Day 29, month 2, leap=1, EDIT_YEAR, btn_up, leap drops to 0 one cycle later -> year_inc_manual one cycle, day 28 on the following cycle.
REQ-025 In EDIT_DAY at day 31, month 12, three tick_day pulses, then btn_mode -> first RUN cycle applies one tick: day 1, month 1, year_inc_auto once; other ticks dropped.
REQ-026 rst asserted during EDIT_MONTH with pending tick -> next cycle mode 0, day 1, month 1, no year pulses in following 3 cycles without stimulus.

Source files
------------

// File: rtl/date_ctrl.sv
// Calendar day/month register with run/edit FSM, deferred day-tick handling
// and year increment/decrement pulses for an external year counter.
module date_ctrl #(
  parameter int unsigned DAY_RST   = 1,
  parameter int unsigned MONTH_RST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_day,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       leap,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic       year_inc_auto,
  output logic       year_inc_manual,
  output logic       year_dec_manual,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    EDIT_YEAR  = 2'd1,
    EDIT_MONTH = 2'd2,
    EDIT_DAY   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] day_d;
  logic [3:0] month_d;
  logic       pend_q, pend_d;
  logic       auto_d, incm_d, decm_d;
  logic [4:0] dim;
  logic       btn_ok, inc, dec, do_tick;

  always_comb begin
    unique case (month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = leap ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  end

  always_comb begin
    state_d = state_q;
    day_d   = day;
    month_d = month;
    pend_d  = pend_q;
    auto_d  = 1'b0;
    incm_d  = 1'b0;
    decm_d  = 1'b0;
    do_tick = 1'b0;
    btn_ok  = !btn_mode && (btn_up ^ btn_down);
    inc     = btn_ok && btn_up;
    dec     = btn_ok && btn_down;

    if (btn_mode) begin
      unique case (state_q)
        RUN:        state_d = EDIT_YEAR;
        EDIT_YEAR:  state_d = EDIT_MONTH;
        EDIT_MONTH: state_d = EDIT_DAY;
        EDIT_DAY:   state_d = RUN;
      endcase
    end

    unique case (state_q)
      RUN: begin
        // A stored tick is consumed first; a new tick in that cycle takes its slot.
        do_tick = pend_q | tick_day;
        pend_d  = pend_q & tick_day;
      end
      EDIT_YEAR: begin
        pend_d = pend_q | tick_day;
        incm_d = inc;
        decm_d = dec;
      end
      EDIT_MONTH: begin
        pend_d = pend_q | tick_day;
        if (inc)      month_d = (month == 4'd12) ? 4'd1 : month + 4'd1;
        else if (dec) month_d = (month == 4'd1) ? 4'd12 : month - 4'd1;
      end
      EDIT_DAY: begin
        pend_d = pend_q | tick_day;
        if (inc)      day_d = (day >= dim) ? 5'd1 : day + 5'd1;
        else if (dec) day_d = (day == 5'd1 || day > dim) ? dim : day - 5'd1;
      end
    endcase

    if (do_tick) begin
      if (day < dim) begin
        day_d = day + 5'd1;
      end else begin
        day_d = 5'd1;
        if (month == 4'd12) begin
          month_d = 4'd1;
          auto_d  = 1'b1;
        end else begin
          month_d = month + 4'd1;
        end
      end
    end else if (!(state_q == EDIT_DAY && btn_ok) && day > dim) begin
      // Day left out of range by a month edit or a leap change.
      day_d = dim;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      day             <= 5'(DAY_RST);
      month           <= 4'(MONTH_RST);
      pend_q          <= 1'b0;
      year_inc_auto   <= 1'b0;
      year_inc_manual <= 1'b0;
      year_dec_manual <= 1'b0;
    end else begin
      state_q         <= state_d;
      day             <= day_d;
      month           <= month_d;
      pend_q          <= pend_d;
      year_inc_auto   <= auto_d;
      year_inc_manual <= incm_d;
      year_dec_manual <= decm_d;
    end
  end

  assign mode = state_q;

endmodule
